control_ns_gen: RTL

Next-state generator for the main control state register. It synchronizes and debounces two raw push-buttons (toggle, clear) and runs a small handshake FSM. The FSM drives `NS` into the state register and watches that register's output `cur_state` to confirm each update was captured. It sits between the board buttons and the state register. It turns one physical press into exactly one state change.

---
 rtl/control_ns_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/control_ns_gen.sv
// ============================================================================
// Module   : control_ns_gen
// Purpose  : Synchronises and debounces the toggle/clear buttons and drives a
//            handshaked next-state value into the main control state register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_ns_gen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int ACK_TIMEOUT     = 4
) (
    input  logic clk_main,
    input  logic reset,
    input  logic btn_toggle,
    input  logic btn_clear,
    input  logic enable,
    input  logic cur_state,
    output logic NS,
    output logic ns_change,
    output logic toggle_db,
    output logic clear_db,
    output logic ack_err
);

    localparam logic [CNT_W-1:0]   c_db_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                 c_ack_w    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_ack_w-1:0] c_ack_last = c_ack_w'(ACK_TIMEOUT - 1);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_ack = 2'd1;
    localparam logic [1:0] c_st_wait_rel = 2'd2;

    // Button index 0 is toggle, index 1 is clear.
    logic [1:0]       w_raw;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_stable;
    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_rise;

    logic [1:0]         r_state;
    logic [c_ack_w-1:0] r_ack_cnt;
    logic               r_ns;
    logic               r_ns_change;
    logic               r_ack_err;

    assign w_raw  = {btn_clear, btn_toggle};
    assign w_rise = r_stable & ~r_prev;

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_meta   <= 2'b00;
            r_sync   <= 2'b00;
            r_stable <= 2'b00;
            r_prev   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            r_prev <= r_stable;
            // A new level is accepted only after an unbroken run of mismatches.
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_db_last) begin
                    r_stable[i] <= r_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ack_cnt   <= '0;
            r_ns        <= 1'b0;
            r_ns_change <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            r_ns_change <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_rise[1]) begin
                        r_ns        <= 1'b0;
                        r_ns_change <= 1'b1;
                        r_ack_cnt   <= '0;
                        r_state     <= c_st_wait_ack;
                    end else if (w_rise[0] && enable) begin
                        r_ns        <= ~cur_state;
                        r_ns_change <= 1'b1;
                        r_ack_cnt   <= '0;
                        r_state     <= c_st_wait_ack;
                    end
                end
                c_st_wait_ack: begin
                    if (w_rise[1]) begin
                        r_ns        <= 1'b0;
                        r_ns_change <= r_ns;
                        r_ack_cnt   <= '0;
                    end else if (cur_state == r_ns) begin
                        r_state <= c_st_wait_rel;
                    end else if (r_ack_cnt == c_ack_last) begin
                        r_ack_err <= 1'b1;
                        r_state   <= c_st_wait_rel;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + c_ack_w'(1);
                    end
                end
                c_st_wait_rel: begin
                    if (w_rise[1]) begin
                        r_ns        <= 1'b0;
                        r_ns_change <= r_ns;
                        r_ack_cnt   <= '0;
                        r_state     <= c_st_wait_ack;
                    end else if (r_stable == 2'b00) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign NS        = r_ns;
    assign ns_change = r_ns_change;
    assign toggle_db = r_stable[0];
    assign clear_db  = r_stable[1];
    assign ack_err   = r_ack_err;

endmodule

`default_nettype wire
